// File: rtl/router_pkt_sink_pkg.sv
// Shared definitions for the router packet sink: FSM encoding, header layout, widths.
package router_defs;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned LEN_W     = 6;
    localparam int unsigned ADDR_W    = 2;
    localparam int unsigned LEFT_W    = LEN_W + 1;   // len+1 reads (payload + parity)
    localparam int unsigned PKT_CNT_W = 16;
    localparam int unsigned ERR_CNT_W = 8;
    localparam int unsigned TMR_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HDR_WAIT = 2'd1,
        ST_BODY     = 2'd2,
        ST_CHECK    = 2'd3
    } state_e;

    // Header byte: {len[5:0], addr[1:0]}
    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [ADDR_W-1:0] addr;
    } hdr_t;

endpackage

// File: rtl/router_pkt_sink_if.sv
// Router FIFO read port plus sink result bus.
// master: router/environment side; slave: the packet sink.
interface router_pkt_sink_if;
    import router_defs::*;

    logic                 vld_out;
    logic [DATA_W-1:0]    data_out;
    logic                 sink_en;
    logic                 read_enb;
    logic [DATA_W-1:0]    pl_data;
    logic                 pl_valid;
    logic                 pkt_done;
    logic [LEN_W-1:0]     pkt_len;
    logic                 parity_err;
    logic                 addr_err;
    logic                 timeout_err;
    logic [PKT_CNT_W-1:0] pkt_cnt;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output vld_out, data_out, sink_en,
        input  read_enb, pl_data, pl_valid, pkt_done, pkt_len,
               parity_err, addr_err, timeout_err, pkt_cnt, err_cnt
    );

    modport slave (
        input  vld_out, data_out, sink_en,
        output read_enb, pl_data, pl_valid, pkt_done, pkt_len,
               parity_err, addr_err, timeout_err, pkt_cnt, err_cnt
    );

endinterface

// File: rtl/router_sink_timer.sv
// Mid-packet stall counter. expire_c is high on the TIMEOUT-th consecutive
// enabled cycle; clr (or expiry) returns the count to zero.
// Ports: clock, resetn, clr, en in; expire_c out (combinational).
module router_sink_timer
    import router_defs::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clock,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic expire_c
);

    logic [TMR_W-1:0] count_q, count_d;

    assign expire_c = en && (count_q == TMR_W'(TIMEOUT - 1));

    // Next count
    always_comb begin
        count_d = count_q;
        if (clr || expire_c) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/router_pkt_sink.sv
// Router output-port packet sink: reads header/payload/parity from the router
// FIFO, forwards payload, checks address and XOR parity, counts packets/errors
// and aborts packets that stall longer than TIMEOUT cycles.
// Ports: clock, resetn; bus (slave) = FIFO read port in, payload/status out.
module router_pkt_sink
    import router_defs::*;
#(
    parameter logic [ADDR_W-1:0] PORT_ADDR = 2'b01,
    parameter int unsigned       TIMEOUT   = 16
) (
    input  logic             clock,
    input  logic             resetn,
    router_pkt_sink_if.slave bus
);

    state_e               state_q, state_d;
    logic [LEFT_W-1:0]    issue_left_q, issue_left_d;
    logic [LEFT_W-1:0]    recv_left_q, recv_left_d;
    logic [DATA_W-1:0]    acc_q, acc_d;
    logic [DATA_W-1:0]    pl_data_q, pl_data_d;
    logic [LEN_W-1:0]     pkt_len_q, pkt_len_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 rd_pend_q, rd_pend_d;
    logic                 pl_valid_q, pl_valid_d;
    logic                 pkt_done_q, pkt_done_d;
    logic                 parity_err_q, parity_err_d;
    logic                 addr_err_q, addr_err_d;
    logic                 timeout_err_q, timeout_err_d;
    logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic read_enb_c, in_pkt_c, byte_rx_c, stall_c, expire_c;
    logic par_bad_c, addr_bad_c;
    hdr_t hdr_c;

    assign hdr_c      = hdr_t'(bus.data_out);
    assign in_pkt_c   = (state_q == ST_HDR_WAIT) || (state_q == ST_BODY);
    // The header read is always in flight during HDR_WAIT
    assign byte_rx_c  = (state_q == ST_HDR_WAIT) || rd_pend_q;
    assign stall_c    = in_pkt_c && !byte_rx_c;
    assign par_bad_c  = (acc_q ^ bus.data_out) != '0;
    assign addr_bad_c = (addr_q != PORT_ADDR);

    router_sink_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clock    (clock),
        .resetn   (resetn),
        .clr      (!stall_c),
        .en       (stall_c),
        .expire_c (expire_c)
    );

    // Next-state, read issue and result strobes
    always_comb begin
        state_d       = state_q;
        issue_left_d  = issue_left_q;
        recv_left_d   = recv_left_q;
        acc_d         = acc_q;
        pl_data_d     = pl_data_q;
        pkt_len_d     = pkt_len_q;
        addr_d        = addr_q;
        rd_pend_d     = 1'b0;
        pl_valid_d    = 1'b0;
        pkt_done_d    = 1'b0;
        parity_err_d  = 1'b0;
        addr_err_d    = 1'b0;
        timeout_err_d = 1'b0;
        pkt_cnt_d     = pkt_cnt_q;
        err_cnt_d     = err_cnt_q;
        read_enb_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                read_enb_c = bus.vld_out && bus.sink_en;
                if (read_enb_c) begin
                    state_d = ST_HDR_WAIT;
                end
            end

            ST_HDR_WAIT: begin
                pkt_len_d    = hdr_c.len;
                addr_d       = hdr_c.addr;
                acc_d        = bus.data_out;
                issue_left_d = LEFT_W'(hdr_c.len) + LEFT_W'(1);
                recv_left_d  = LEFT_W'(hdr_c.len) + LEFT_W'(1);
                state_d      = ST_BODY;
            end

            ST_BODY: begin
                // No new read on the abort cycle so nothing is left in flight
                read_enb_c = bus.vld_out && bus.sink_en &&
                             (issue_left_q != '0) && !expire_c;
                rd_pend_d  = read_enb_c;
                if (read_enb_c) begin
                    issue_left_d = issue_left_q - LEFT_W'(1);
                end
                if (rd_pend_q) begin
                    acc_d       = acc_q ^ bus.data_out;
                    recv_left_d = recv_left_q - LEFT_W'(1);
                    if (recv_left_q > LEFT_W'(1)) begin
                        pl_data_d  = bus.data_out;
                        pl_valid_d = 1'b1;
                    end else begin
                        state_d      = ST_CHECK;
                        pkt_done_d   = 1'b1;
                        parity_err_d = par_bad_c;
                        addr_err_d   = addr_bad_c;
                        pkt_cnt_d    = pkt_cnt_q + PKT_CNT_W'(1);
                        if ((par_bad_c || addr_bad_c) && (err_cnt_q != '1)) begin
                            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                        end
                    end
                end else if (expire_c) begin
                    state_d       = ST_IDLE;
                    timeout_err_d = 1'b1;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                    end
                end
            end

            ST_CHECK: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            issue_left_q  <= '0;
            recv_left_q   <= '0;
            acc_q         <= '0;
            pl_data_q     <= '0;
            pkt_len_q     <= '0;
            addr_q        <= '0;
            rd_pend_q     <= 1'b0;
            pl_valid_q    <= 1'b0;
            pkt_done_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            addr_err_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            pkt_cnt_q     <= '0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            issue_left_q  <= issue_left_d;
            recv_left_q   <= recv_left_d;
            acc_q         <= acc_d;
            pl_data_q     <= pl_data_d;
            pkt_len_q     <= pkt_len_d;
            addr_q        <= addr_d;
            rd_pend_q     <= rd_pend_d;
            pl_valid_q    <= pl_valid_d;
            pkt_done_q    <= pkt_done_d;
            parity_err_q  <= parity_err_d;
            addr_err_q    <= addr_err_d;
            timeout_err_q <= timeout_err_d;
            pkt_cnt_q     <= pkt_cnt_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    // read_enb is held low while reset is asserted
    assign bus.read_enb    = read_enb_c && resetn;
    assign bus.pl_data     = pl_data_q;
    assign bus.pl_valid    = pl_valid_q;
    assign bus.pkt_done    = pkt_done_q;
    assign bus.pkt_len     = pkt_len_q;
    assign bus.parity_err  = parity_err_q;
    assign bus.addr_err    = addr_err_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.pkt_cnt     = pkt_cnt_q;
    assign bus.err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_router_pkt_sink.sv
// Directed bench for router_pkt_sink: a byte FIFO model feeds the sink,
// monitors tally reads, payload bytes and strobes, and checks compare deltas.
module tb_router_pkt_sink;

    logic clock = 1'b0;
    logic resetn;

    router_pkt_sink_if bus();

    router_pkt_sink #(.PORT_ADDR(2'b01), .TIMEOUT(16)) u_dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    // Router FIFO model: data_out valid the cycle after read_enb is sampled
    logic [7:0] mem [0:511];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       flush  = 1'b0;
    logic [7:0] exp_q [$];

    assign bus.vld_out = (rd_ptr != wr_ptr);

    always @(posedge clock) begin
        if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (bus.read_enb) begin
            bus.data_out <= mem[rd_ptr[8:0]];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    // Monitors
    int   cyc = 0, rd_cnt = 0, last_rd_cyc = 0;
    int   pl_cnt = 0, pl_bad = 0, done_cnt = 0, tmo_cnt = 0, tmo_cyc = 0;
    int   last_par = 0, last_addr = 0;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (resetn && bus.read_enb) begin
            rd_cnt      <= rd_cnt + 1;
            last_rd_cyc <= cyc;
        end
    end

    always @(negedge clock) begin
        if (bus.pl_valid) begin
            pl_cnt++;
            if (exp_q.size() == 0) pl_bad++;
            else begin
                if (bus.pl_data != exp_q[0]) pl_bad++;
                void'(exp_q.pop_front());
            end
        end
        if (bus.pkt_done) begin
            done_cnt++;
            last_par  = int'(bus.parity_err);
            last_addr = int'(bus.addr_err);
        end
        if (bus.timeout_err) begin
            tmo_cnt++;
            tmo_cyc = cyc;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int stat(input int which);
        case (which)
            0:       return done_cnt;
            1:       return pl_cnt;
            default: return tmo_cnt;
        endcase
    endfunction

    // Wait (bounded) until monitor tally 'which' reaches target
    task automatic wait_for(input int which, input int target, input int budget, input string tag);
        int k = 0;
        while (stat(which) < target && k < budget) begin
            @(negedge clock); #1;
            k++;
        end
        check_eq(tag, (stat(which) >= target) ? target : stat(which), target);
    endtask

    // Header, len payload bytes, parity (optionally corrupted); push first n_bytes
    task automatic push_pkt(input int len, input logic [1:0] addr, input logic [7:0] par_flip,
                            input int n_bytes, input logic [7:0] seed);
        logic [7:0] pkt [$];
        logic [7:0] h, p, par;
        h   = {6'(len), addr};
        par = h;
        pkt.push_back(h);
        for (int i = 0; i < len; i++) begin
            p = seed + 8'(i * 13);
            pkt.push_back(p);
            par ^= p;
        end
        pkt.push_back(par ^ par_flip);
        for (int i = 0; i < n_bytes; i++) begin
            mem[wr_ptr[8:0]] = pkt[i];
            wr_ptr++;
            if (i >= 1 && i <= len) exp_q.push_back(pkt[i]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b_rd, b_pl, b_done, b_tmo;
        resetn      = 1'b0;
        bus.sink_en = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        check_eq("rst_read_enb", int'(bus.read_enb), 0);
        check_eq("rst_pl_valid", int'(bus.pl_valid), 0);
        check_eq("rst_pkt_cnt",  int'(bus.pkt_cnt), 0);
        check_eq("rst_err_cnt",  int'(bus.err_cnt), 0);
        check_eq("rst_pkt_len",  int'(bus.pkt_len), 0);
        check_eq("rst_pkt_done", int'(bus.pkt_done), 0);
        resetn = 1'b1;

        // len=14, good packet
        @(negedge clock);
        b_rd = rd_cnt; b_pl = pl_cnt; b_done = done_cnt;
        push_pkt(14, 2'b01, 8'h00, 16, 8'h20);
        wait_for(0, b_done + 1, 100, "t1_done");
        repeat (3) @(negedge clock); #1;
        check_eq("t1_reads",   rd_cnt - b_rd, 16);
        check_eq("t1_pl",      pl_cnt - b_pl, 14);
        check_eq("t1_par_err", last_par, 0);
        check_eq("t1_addr_err", last_addr, 0);
        check_eq("t1_pkt_cnt", int'(bus.pkt_cnt), 1);
        check_eq("t1_err_cnt", int'(bus.err_cnt), 0);
        check_eq("t1_pkt_len", int'(bus.pkt_len), 14);
        check_eq("t1_payload", pl_bad, 0);

        // same packet, parity byte flipped
        b_rd = rd_cnt; b_pl = pl_cnt; b_done = done_cnt;
        push_pkt(14, 2'b01, 8'h01, 16, 8'h20);
        wait_for(0, b_done + 1, 100, "t2_done");
        repeat (3) @(negedge clock); #1;
        check_eq("t2_par_err", last_par, 1);
        check_eq("t2_pl",      pl_cnt - b_pl, 14);
        check_eq("t2_err_cnt", int'(bus.err_cnt), 1);
        check_eq("t2_pkt_cnt", int'(bus.pkt_cnt), 2);

        // wrong address, len=3
        b_rd = rd_cnt; b_pl = pl_cnt; b_done = done_cnt;
        push_pkt(3, 2'b10, 8'h00, 5, 8'h40);
        wait_for(0, b_done + 1, 100, "t3_done");
        repeat (3) @(negedge clock); #1;
        check_eq("t3_reads",    rd_cnt - b_rd, 5);
        check_eq("t3_addr_err", last_addr, 1);
        check_eq("t3_par_err",  last_par, 0);
        check_eq("t3_pl",       pl_cnt - b_pl, 3);
        check_eq("t3_err_cnt",  int'(bus.err_cnt), 2);

        // len=0 then len=5 back-to-back
        b_rd = rd_cnt; b_pl = pl_cnt; b_done = done_cnt;
        push_pkt(0, 2'b01, 8'h00, 2, 8'h00);
        push_pkt(5, 2'b01, 8'h00, 7, 8'h60);
        wait_for(0, b_done + 2, 100, "t4_done");
        repeat (3) @(negedge clock); #1;
        check_eq("t4_reads",   rd_cnt - b_rd, 9);
        check_eq("t4_pl",      pl_cnt - b_pl, 5);
        check_eq("t4_pkt_cnt", int'(bus.pkt_cnt), 5);
        check_eq("t4_pkt_len", int'(bus.pkt_len), 5);
        check_eq("t4_par_err", last_par, 0);

        // sink_en low for 5 cycles mid-body
        b_rd = rd_cnt; b_pl = pl_cnt; b_done = done_cnt; b_tmo = tmo_cnt;
        push_pkt(10, 2'b01, 8'h00, 12, 8'h80);
        wait_for(1, b_pl + 3, 100, "t5_mid");
        bus.sink_en = 1'b0;
        repeat (5) @(negedge clock);
        bus.sink_en = 1'b1;
        wait_for(0, b_done + 1, 100, "t5_done");
        repeat (3) @(negedge clock); #1;
        check_eq("t5_timeout", tmo_cnt - b_tmo, 0);
        check_eq("t5_reads",   rd_cnt - b_rd, 12);
        check_eq("t5_pl",      pl_cnt - b_pl, 10);
        check_eq("t5_par_err", last_par, 0);
        check_eq("t5_pkt_cnt", int'(bus.pkt_cnt), 6);

        // FIFO runs dry after 4 payload bytes -> timeout
        b_rd = rd_cnt; b_pl = pl_cnt; b_done = done_cnt; b_tmo = tmo_cnt;
        push_pkt(10, 2'b01, 8'h00, 5, 8'hA0);
        wait_for(2, b_tmo + 1, 80, "t6_timeout");
        repeat (3) @(negedge clock); #1;
        check_eq("t6_tmo_cnt",   tmo_cnt - b_tmo, 1);
        check_eq("t6_no_done",   done_cnt - b_done, 0);
        check_eq("t6_stall_len", tmo_cyc - last_rd_cyc, 18);
        check_eq("t6_pl",        pl_cnt - b_pl, 4);
        check_eq("t6_err_cnt",   int'(bus.err_cnt), 3);
        check_eq("t6_pkt_cnt",   int'(bus.pkt_cnt), 6);

        // clean packet after the abort
        b_pl = pl_cnt; b_done = done_cnt;
        push_pkt(2, 2'b01, 8'h00, 4, 8'hB0);
        wait_for(0, b_done + 1, 100, "t7_done");
        repeat (3) @(negedge clock); #1;
        check_eq("t7_pkt_cnt", int'(bus.pkt_cnt), 7);
        check_eq("t7_err_cnt", int'(bus.err_cnt), 3);
        check_eq("t7_pl",      pl_cnt - b_pl, 2);
        check_eq("t7_payload", pl_bad, 0);

        // reset while payload byte 7 is in flight
        b_pl = pl_cnt;
        push_pkt(10, 2'b01, 8'h00, 12, 8'hC0);
        wait_for(1, b_pl + 6, 100, "t8_mid");
        resetn = 1'b0;
        flush  = 1'b1;
        #1;
        check_eq("t8_pkt_cnt",  int'(bus.pkt_cnt), 0);
        check_eq("t8_err_cnt",  int'(bus.err_cnt), 0);
        check_eq("t8_pl_valid", int'(bus.pl_valid), 0);
        check_eq("t8_pl_data",  int'(bus.pl_data), 0);
        check_eq("t8_pkt_len",  int'(bus.pkt_len), 0);
        check_eq("t8_read_enb", int'(bus.read_enb), 0);
        repeat (2) @(negedge clock);
        flush = 1'b0;
        exp_q.delete();
        resetn = 1'b1;
        @(negedge clock);
        b_rd = rd_cnt; b_pl = pl_cnt; b_done = done_cnt;
        push_pkt(4, 2'b01, 8'h00, 6, 8'hD0);
        wait_for(0, b_done + 1, 100, "t9_done");
        repeat (3) @(negedge clock); #1;
        check_eq("t9_reads",    rd_cnt - b_rd, 6);
        check_eq("t9_pl",       pl_cnt - b_pl, 4);
        check_eq("t9_pkt_cnt",  int'(bus.pkt_cnt), 1);
        check_eq("t9_err_cnt",  int'(bus.err_cnt), 0);
        check_eq("t9_par_err",  last_par, 0);
        check_eq("t9_addr_err", last_addr, 0);
        check_eq("t9_payload",  pl_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/router_pkt_sink.md
ROUTER_PKT_SINK -- requirements
Module: router_pkt_sink

Interface
REQ-001 Parameter PORT_ADDR, default 2'b01: destination address this sink expects in header bits [1:0].
REQ-002 Parameter TIMEOUT, default 16: stall cycles mid-packet before abort; range 2..255.
REQ-003 clock  input  1  single clock; all state changes on the rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 vld_out  input  1  router output FIFO non-empty.
REQ-006 data_out  input  8  router FIFO read data; valid the cycle after read_enb was sampled high.
REQ-007 sink_en  input  1  consumer throttle; low suspends new reads.
REQ-008 read_enb  output  1  FIFO read request, combinational from registered state, vld_out, sink_en.
REQ-009 pl_data  output  8  forwarded payload byte, registered.
REQ-010 pl_valid  output  1  one-cycle strobe per payload byte.
REQ-011 pkt_done  output  1  one-cycle strobe at end of every completed packet.
REQ-012 pkt_len  output  6  payload length of the last header, held until next header.
REQ-013 parity_err  output  1  strobe with pkt_done when XOR check fails.
REQ-014 addr_err  output  1  strobe with pkt_done when header addr != PORT_ADDR.
REQ-015 timeout_err  output  1  one-cycle strobe on mid-packet abort.
REQ-016 pkt_cnt  output  16  completed packets, wraps at 2^16.
REQ-017 err_cnt  output  8  packets with any error (incl. timeout), saturates at 255.

Function
REQ-018 Packet format: header {len[5:0],addr[1:0]}, len payload bytes (0..63), parity byte = XOR of header and all payload.
REQ-019 FSM states IDLE, HDR_WAIT, BODY, CHECK; encoding binary.
REQ-020 IDLE: read_enb = vld_out & sink_en; when read_enb=1 at an edge -> HDR_WAIT.
REQ-021 HDR_WAIT: read_enb=0; next edge captures data_out as header, loads pkt_len, seeds parity accumulator, sets issue_left = len+1, recv_left = len+1 -> BODY.
REQ-022 BODY: read_enb = vld_out & sink_en & (issue_left != 0); each issued read decrements issue_left; sink never over-reads into the next packet.
REQ-023 BODY: each returned byte (read issued previous cycle) decrements recv_left and XORs into accumulator; when recv_left > 1 it is payload: pl_data/pl_valid asserted the following cycle.
REQ-024 BODY: byte returned when recv_left == 1 is parity -> CHECK.
REQ-025 CHECK lasts exactly one cycle: pkt_done=1, parity_err = (accumulator != 0 after including parity byte), addr_err per REQ-014, pkt_cnt+1, err_cnt+1 if any error; -> IDLE; read_enb=0.
REQ-026 Back-to-back packets: minimum 2 idle cycles (CHECK, IDLE issue) between parity byte and next header read.
REQ-027 Stall counter: in HDR_WAIT/BODY, counts cycles with no returned byte; cleared on any returned byte; at TIMEOUT -> timeout_err strobe, err_cnt+1, pkt_cnt unchanged, -> IDLE, no pkt_done.
REQ-028 sink_en low never triggers data loss: an already-issued read is still captured the next cycle.
REQ-029 len=0: exactly two reads (header, parity), zero pl_valid, pkt_done still asserted.
REQ-030 Errors do not discard framing: addr/parity-error packets are fully drained and payload forwarded.

Reset
REQ-031 resetn low asynchronously forces IDLE, read_enb=0, all strobes 0, pl_data=0, pkt_len=0, pkt_cnt=0, err_cnt=0, counters and accumulator 0.
REQ-032 Reset mid-packet abandons the packet without any strobe; first post-reset read is treated as a header.

Structure
REQ-033 Shared package/include router_defs holds state encodings, header field widths (LEN_W=6, ADDR_W=2), and DATA_W=8.
REQ-034 One sub-module router_sink_timer implements the TIMEOUT stall counter (clear, enable, expire outputs).

Verification
REQ-035 len=14, addr=01, correct parity, vld_out steady -> 1 header read, 15 body reads, 14 pl_valid matching bytes, pkt_done, no errors, pkt_cnt=1.
REQ-036 Same packet with parity byte XOR 8'h01 -> pkt_done with parity_err=1, err_cnt=1, payload still forwarded.
REQ-037 Header addr=10 with PORT_ADDR=01, len=3 -> addr_err=1 with pkt_done, 4 body reads only.
REQ-038 len=0 packet then len=5 packet back-to-back -> pkt_done twice, pkt_cnt=2, 5 pl_valid total, no over-read.
REQ-039 sink_en low for 5 cycles mid-BODY (TIMEOUT=16) -> no loss, no timeout; vld_out low 16 cycles mid-BODY -> timeout_err, IDLE, err_cnt+1.
REQ-040 resetn low during payload byte 7 -> all outputs/counters 0 asynchronously; next packet received cleanly.
